// File: rtl/matrix_scan_driver.sv
// matrix_scan_driver
//   Scans a 16x16 LED matrix one row at a time. For each row it fetches the pixel
//   word from the frame buffer, shifts it out MSB first on the column chain,
//   advances the one-hot row token on the row chain, latches the columns and
//   lights the row for ON_CYCLES clocks.
//
// Ports
//   clk         system clock (single domain)
//   reset       synchronous active-high reset
//   enable      start / continue scanning; sampled at row boundaries only
//   row_addr    frame-buffer row being fetched
//   row_data    pixels of row_addr, valid one cycle after row_addr changes
//   frame_start one-cycle pulse on the first fetch cycle of row 0
//   CSDI/CCLK   column serial data / clock
//   RSDI/RCLK   row serial data / clock
//   LE          column latch enable
//   OEB         output enable, active low
module matrix_scan_driver #(
    parameter int unsigned CLKDIV    = 1,
    parameter int unsigned ON_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [3:0]  row_addr,
    input  logic [15:0] row_data,
    output logic        frame_start,
    output logic        CSDI,
    output logic        CCLK,
    output logic        RSDI,
    output logic        RCLK,
    output logic        LE,
    output logic        OEB
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StFetch   = 3'd1;
    localparam logic [2:0] StShift   = 3'd2;
    localparam logic [2:0] StRowStep = 3'd3;
    localparam logic [2:0] StLatch   = 3'd4;
    localparam logic [2:0] StOn      = 3'd5;

    // One counter serves every phase, so it must hold the longest one.
    localparam int unsigned CntMax = (ON_CYCLES > 2 * CLKDIV) ? ON_CYCLES : 2 * CLKDIV;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] HalfCnt   = CntW'(CLKDIV);
    localparam logic [CntW-1:0] PhaseLast = CntW'(2 * CLKDIV - 1);
    localparam logic [CntW-1:0] LatchLast = CntW'(CLKDIV - 1);
    localparam logic [CntW-1:0] OnLast    = CntW'(ON_CYCLES - 1);
    localparam logic [CntW-1:0] FetchLast = CntW'(1);

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      bit_q, bit_d;
    logic [3:0]      row_q, row_d;
    logic [15:0]     sr_q, sr_d;

    logic [3:0] row_addr_q, row_addr_d;
    logic       frame_start_q, frame_start_d;
    logic       csdi_q, csdi_d;
    logic       cclk_q, cclk_d;
    logic       rsdi_q, rsdi_d;
    logic       rclk_q, rclk_d;
    logic       le_q, le_d;
    logic       oeb_q, oeb_d;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        row_d   = row_q;
        sr_d    = sr_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = StFetch;
                    row_d   = 4'd0;
                end
            end
            StFetch: begin
                if (cnt_q == FetchLast) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    bit_d   = 4'd0;
                    sr_d    = row_data;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShift: begin
                if (cnt_q == PhaseLast) begin
                    cnt_d = '0;
                    sr_d  = {sr_q[14:0], 1'b0};
                    if (bit_q == 4'd15) begin
                        state_d = StRowStep;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRowStep: begin
                if (cnt_q == PhaseLast) begin
                    state_d = StLatch;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLatch: begin
                if (cnt_q == LatchLast) begin
                    state_d = StOn;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StOn: begin
                if (cnt_q == OnLast) begin
                    cnt_d   = '0;
                    row_d   = row_q + 1'b1;
                    state_d = enable ? StFetch : StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so every pin comes straight off a flop
    // and lines up with the state it belongs to.
    always_comb begin
        row_addr_d    = row_d;
        frame_start_d = (state_d == StFetch) && (cnt_d == '0) && (row_d == 4'd0);
        cclk_d        = (state_d == StShift) && (cnt_d >= HalfCnt);
        rclk_d        = (state_d == StRowStep) && (cnt_d >= HalfCnt);
        le_d          = (state_d == StLatch);
        oeb_d         = (state_d != StOn);
        // Serial data only moves at the start of a low clock phase and holds otherwise.
        csdi_d        = csdi_q;
        if (state_d == StShift) begin
            csdi_d = sr_d[15];
        end
        rsdi_d = rsdi_q;
        if (state_d == StRowStep) begin
            rsdi_d = (row_d == 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            bit_q         <= 4'd0;
            row_q         <= 4'd0;
            sr_q          <= 16'd0;
            row_addr_q    <= 4'd0;
            frame_start_q <= 1'b0;
            csdi_q        <= 1'b0;
            cclk_q        <= 1'b0;
            rsdi_q        <= 1'b0;
            rclk_q        <= 1'b0;
            le_q          <= 1'b0;
            oeb_q         <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_q         <= bit_d;
            row_q         <= row_d;
            sr_q          <= sr_d;
            row_addr_q    <= row_addr_d;
            frame_start_q <= frame_start_d;
            csdi_q        <= csdi_d;
            cclk_q        <= cclk_d;
            rsdi_q        <= rsdi_d;
            rclk_q        <= rclk_d;
            le_q          <= le_d;
            oeb_q         <= oeb_d;
        end
    end

    assign row_addr    = row_addr_q;
    assign frame_start = frame_start_q;
    assign CSDI        = csdi_q;
    assign CCLK        = cclk_q;
    assign RSDI        = rsdi_q;
    assign RCLK        = rclk_q;
    assign LE          = le_q;
    assign OEB         = oeb_q;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// tb_matrix_scan_driver
//   Directed bench for matrix_scan_driver: one instance with default parameters
//   (u_a) and one with CLKDIV=3, ON_CYCLES=4 (u_b). Each frame buffer is a
//   registered read of a fixed row pattern table.
module tb_matrix_scan_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults
    logic        reset_a = 1'b1, enable_a = 1'b0;
    logic [3:0]  row_addr_a;
    logic [15:0] row_data_a = 16'd0;
    logic        frame_start_a, CSDI_a, CCLK_a, RSDI_a, RCLK_a, LE_a, OEB_a;

    // Instance B: CLKDIV=3, ON_CYCLES=4
    logic        reset_b = 1'b1, enable_b = 1'b0;
    logic [3:0]  row_addr_b;
    logic [15:0] row_data_b = 16'd0;
    logic        frame_start_b, CSDI_b, CCLK_b, RSDI_b, RCLK_b, LE_b, OEB_b;

    matrix_scan_driver u_a (
        .clk(clk), .reset(reset_a), .enable(enable_a), .row_addr(row_addr_a),
        .row_data(row_data_a), .frame_start(frame_start_a), .CSDI(CSDI_a), .CCLK(CCLK_a),
        .RSDI(RSDI_a), .RCLK(RCLK_a), .LE(LE_a), .OEB(OEB_a)
    );

    matrix_scan_driver #(.CLKDIV(3), .ON_CYCLES(4)) u_b (
        .clk(clk), .reset(reset_b), .enable(enable_b), .row_addr(row_addr_b),
        .row_data(row_data_b), .frame_start(frame_start_b), .CSDI(CSDI_b), .CCLK(CCLK_b),
        .RSDI(RSDI_b), .RCLK(RCLK_b), .LE(LE_b), .OEB(OEB_b)
    );

    // Row pattern table: row 0 is 16'h8001, others differ per row.
    function automatic logic [15:0] pat(input logic [3:0] r);
        if (r == 4'd0) return 16'h8001;
        return {r, ~r, 4'hA, r};
    endfunction

    always @(posedge clk) begin
        row_data_a <= pat(row_addr_a);
        row_data_b <= pat(row_addr_b);
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor state for instance A, updated once per negedge by tick().
    int          cyc = 0;
    int          n_cclk = 0, n_rclk = 0, n_oeb = 0, n_le = 0, n_fs = 0;
    int          fs_last = 0, fs_prev = 0;
    logic [15:0] col_word = 16'd0;
    logic        last_rise_rsdi = 1'b0;
    int          rsdi_ones[$];
    logic        p_cclk = 1'b0, p_rclk = 1'b0, p_csdi = 1'b0;

    // Per-row snapshots and deltas.
    int row_t0 = 0, s_cclk = 0, s_rclk = 0, s_oeb = 0, s_le = 0, s_fs = 0;
    int period = 0, d_cclk = 0, d_rclk = 0, d_oeb = 0, d_le = 0, d_fs = 0;

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (CCLK_a && !p_cclk) begin
            col_word = {col_word[14:0], CSDI_a};
            n_cclk++;
        end
        if (RCLK_a && !p_rclk) begin
            if (RSDI_a) rsdi_ones.push_back(n_rclk);
            last_rise_rsdi = RSDI_a;
            n_rclk++;
        end
        if (!OEB_a) n_oeb++;
        if (LE_a) n_le++;
        if (frame_start_a) begin
            fs_prev = fs_last;
            fs_last = cyc;
            n_fs++;
        end
        check("csdi_moved_while_cclk_high", CCLK_a && (CSDI_a !== p_csdi), 0);
        check("le_while_oeb_low", LE_a && !OEB_a, 0);
        check("activity_while_lit", !OEB_a && (CCLK_a || RCLK_a || LE_a), 0);
        p_cclk = CCLK_a;
        p_rclk = RCLK_a;
        p_csdi = CSDI_a;
    endtask

    task automatic snap();
        row_t0 = cyc;
        s_cclk = n_cclk;
        s_rclk = n_rclk;
        s_oeb  = n_oeb;
        s_le   = n_le;
        s_fs   = n_fs;
    endtask

    task automatic deltas();
        period = cyc - row_t0;
        d_cclk = n_cclk - s_cclk;
        d_rclk = n_rclk - s_rclk;
        d_oeb  = n_oeb - s_oeb;
        d_le   = n_le - s_le;
        d_fs   = n_fs - s_fs;
    endtask

    // Waits for row_addr_a to change, then records the finished row's deltas.
    task automatic wait_next_row();
        logic [3:0] a0;
        int         n;
        a0 = row_addr_a;
        n  = 0;
        while (row_addr_a == a0 && n < 2000) begin
            tick();
            n++;
        end
        check("row_change_within_bound", n < 2000, 1);
        deltas();
        snap();
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_row_addr", row_addr_a, 0);
        check("rst_frame_start", frame_start_a, 0);
        check("rst_csdi", CSDI_a, 0);
        check("rst_cclk", CCLK_a, 0);
        check("rst_rsdi", RSDI_a, 0);
        check("rst_rclk", RCLK_a, 0);
        check("rst_le", LE_a, 0);
        check("rst_oeb", OEB_a, 1);
        check("rst_b_oeb", OEB_b, 1);

        // Enable: frame_start on the first cycle after
        reset_a  = 1'b0;
        enable_a = 1'b1;
        tick();
        check("fs_first", frame_start_a, 1);
        check("row0_addr", row_addr_a, 0);
        snap();
        tick();
        check("fs_one_cycle", frame_start_a, 0);

        // Row 0 with 16'h8001
        wait_next_row();
        check("row0_period", period, 293);
        check("row0_cclk_rises", d_cclk, 16);
        check("row0_csdi_word", col_word, 16'h8001);
        check("row0_rclk_rises", d_rclk, 1);
        check("row0_rsdi", last_rise_rsdi, 1);
        check("row0_oeb_low", d_oeb, 256);
        check("row0_le", d_le, 1);
        check("row1_addr", row_addr_a, 1);

        // Rows 1..15, wrap to 0
        for (int r = 1; r < 16; r++) begin
            wait_next_row();
            check("row_period", period, 293);
            check("row_csdi_word", col_word, pat(4'(r)));
            check("row_rsdi", last_rise_rsdi, 0);
            check("row_oeb_low", d_oeb, 256);
            check("row_addr_step", row_addr_a, (r + 1) % 16);
        end
        check("frame_period", fs_last - fs_prev, 4688);

        // Rows 16..32: token injected on rises 0, 16, 32 only
        for (int r = 0; r < 17; r++) wait_next_row();
        check("rsdi_ones_count", rsdi_ones.size(), 3);
        if (rsdi_ones.size() == 3) begin
            check("rsdi_one_0", rsdi_ones[0], 0);
            check("rsdi_one_1", rsdi_ones[1], 16);
            check("rsdi_one_2", rsdi_ones[2], 32);
        end

        // Disable during SHIFT of row 5
        while (row_addr_a != 4'd5 && cyc < 40000) wait_next_row();
        check("reached_row5", row_addr_a, 5);
        repeat (10) tick();
        enable_a = 1'b0;
        wait_next_row();
        check("row5_period", period, 293);
        check("row5_oeb_low", d_oeb, 256);
        check("row5_csdi_word", col_word, pat(4'd5));
        repeat (20) tick();
        deltas();
        check("idle_oeb", OEB_a, 1);
        check("idle_no_cclk", d_cclk, 0);
        check("idle_no_oeb_low", d_oeb, 0);
        enable_a = 1'b1;
        tick();
        check("reenable_fs", frame_start_a, 1);
        check("reenable_row0", row_addr_a, 0);
        snap();

        // Reset during ON of row 3
        for (int r = 0; r < 3; r++) wait_next_row();
        check("reached_row3", row_addr_a, 3);
        repeat (47) tick();
        check("row3_in_on", OEB_a, 0);
        reset_a = 1'b1;
        tick();
        check("rst_on_oeb", OEB_a, 1);
        check("rst_on_cclk", CCLK_a, 0);
        check("rst_on_rclk", RCLK_a, 0);
        check("rst_on_le", LE_a, 0);
        check("rst_on_row_addr", row_addr_a, 0);
        snap();
        repeat (20) tick();
        deltas();
        check("rst_hold_cclk", d_cclk, 0);
        check("rst_hold_rclk", d_rclk, 0);
        check("rst_hold_le", d_le, 0);
        check("rst_hold_oeb", d_oeb, 0);
        check("rst_hold_fs", d_fs, 0);
        reset_a = 1'b0;
        tick();
        check("post_rst_fs", frame_start_a, 1);

        // Instance B: CLKDIV=3, ON_CYCLES=4
        reset_b  = 1'b0;
        enable_b = 1'b1;
        tick();
        check("b_fs", frame_start_b, 1);
        begin
            int          n, hi, rises, last, gmin, gmax, le, oebl, rhi;
            logic        pc, pd;
            logic [15:0] word;
            n = 0; hi = 0; rises = 0; last = 0; gmin = 999; gmax = 0;
            le = 0; oebl = 0; rhi = 0; word = 16'd0;
            pc = CCLK_b;
            pd = CSDI_b;
            while (row_addr_b == 4'd0 && n < 500) begin
                tick();
                n++;
                if (CCLK_b) hi++;
                if (CCLK_b && !pc) begin
                    word = {word[14:0], CSDI_b};
                    if (rises > 0) begin
                        if (n - last < gmin) gmin = n - last;
                        if (n - last > gmax) gmax = n - last;
                    end
                    last = n;
                    rises++;
                end
                check("b_csdi_moved_while_cclk_high", CCLK_b && (CSDI_b !== pd), 0);
                if (LE_b) le++;
                if (!OEB_b) oebl++;
                if (RCLK_b) rhi++;
                pc = CCLK_b;
                pd = CSDI_b;
            end
            check("b_period", n, 111);
            check("b_cclk_rises", rises, 16);
            check("b_cclk_high_cycles", hi, 48);
            check("b_cclk_gap_min", gmin, 6);
            check("b_cclk_gap_max", gmax, 6);
            check("b_le_cycles", le, 3);
            check("b_oeb_low", oebl, 4);
            check("b_rclk_high", rhi, 3);
            check("b_csdi_word", word, 16'h8001);
            check("b_rsdi", RSDI_b, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_scan_driver.md
MATRIX_SCAN_DRIVER -- requirements
Module: matrix_scan_driver

Interface
REQ-001 The block SHALL have parameter CLKDIV, default 1, meaning clk cycles per half-period of CCLK/RCLK and per LE pulse (legal range >=1).
REQ-002 The block SHALL have parameter ON_CYCLES, default 256, meaning clk cycles the latched row is lit (legal range >=1).
REQ-003 The block SHALL have port clk, input, 1, system clock; all logic is in this single clock domain.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port enable, input, 1, which starts and continues scanning while high.
REQ-006 The block SHALL have port row_addr, output, 4, the frame-buffer row being fetched.
REQ-007 The block SHALL have port row_data, input, 16, the frame-buffer pixels of row_addr, valid one cycle after row_addr changes.
REQ-008 The block SHALL have port frame_start, output, 1, a one-cycle pulse when the scan of row 0 begins.
REQ-009 The block SHALL have ports CSDI, CCLK, RSDI, RCLK, LE and OEB, each output, 1: column serial data/clock, row serial data/clock, column latch enable, and output enable (active low).

Function
REQ-010 The FSM SHALL have states IDLE, FETCH, SHIFT, ROWSTEP, LATCH and ON.
REQ-011 In IDLE with enable=1, the FSM SHALL move to FETCH with row counter 0; with enable=0 it SHALL remain in IDLE.
REQ-012 FETCH SHALL last exactly 2 cycles with row_addr = row counter, and SHALL load row_data into a 16-bit shift register at the end of the 2nd cycle.
REQ-013 frame_start SHALL be 1 during the first FETCH cycle of row 0 only.
REQ-014 SHIFT SHALL output 16 bits MSB first (bit 15 = column 0); for each bit, CSDI is stable and CCLK=0 for CLKDIV cycles, then CCLK=1 for CLKDIV cycles, so SHIFT lasts 32*CLKDIV cycles.
REQ-015 CSDI SHALL change only while CCLK=0.
REQ-016 ROWSTEP SHALL drive RSDI = 1 if the row counter is 0 and 0 otherwise, with RCLK=0 for CLKDIV cycles, then RCLK=1 for CLKDIV cycles.
REQ-017 As a result of REQ-016, the one-hot token advances one row per row period.
REQ-018 LATCH SHALL hold LE=1 and OEB=1 for CLKDIV cycles.
REQ-019 ON SHALL hold OEB=0 and LE=0 for ON_CYCLES cycles.
REQ-020 OEB SHALL be 1 in every state other than ON.
REQ-021 Row period SHALL be 2 + 34*CLKDIV + 1*CLKDIV + ON_CYCLES cycles, which is 293 for the defaults.
REQ-022 At the end of ON, the row counter SHALL increment modulo 16 (15 wraps to 0), and the FSM SHALL go to FETCH if enable=1, else to IDLE.
REQ-023 enable deasserted mid-row SHALL NOT abort the row; the current row SHALL complete through ON.
REQ-024 On the IDLE->FETCH transition after a disable, the row counter SHALL restart at 0.
REQ-025 Outside their active phases, CCLK, RCLK and LE SHALL be 0, and CSDI and RSDI SHALL hold their last value.
REQ-026 All outputs SHALL be registered, with no combinational path from row_data or enable to any output.
REQ-027 Internal cycle counters SHALL be sized for ON_CYCLES and 2*CLKDIV without overflow.

Reset
REQ-028 While reset=1 at a clk edge, the block SHALL enter IDLE with row counter 0 and all divider counters 0.
REQ-029 While reset=1 at a clk edge, the block SHALL set row_addr=0, frame_start=0, CSDI=0, CCLK=0, RSDI=0, RCLK=0, LE=0 and OEB=1.
REQ-030 Reset asserted mid-row (including during SHIFT or ON) SHALL take effect at the next edge; no partial CCLK/RCLK/LE pulse SHALL extend past it.
REQ-031 reset SHALL have priority over enable.

Verification
REQ-032 Reset then enable=1, defaults, with row_data=16'h8001 for all rows -> frame_start at cycle 1; CSDI sequence 1,0x14,1; 16 CCLK rising edges; RSDI=1 on the first RCLK rise; OEB=0 for exactly 256 cycles; row period 293.
REQ-033 Run 16 rows -> row_addr steps 0..15 and wraps to 0; RSDI=1 on RCLK rises 0, 16, 32 only; frame_start pulses every 4688 cycles.
REQ-034 CLKDIV=3, ON_CYCLES=4 -> CCLK high and low phases are 3 cycles each; LE high 3 cycles; row period 2+102+3+4 = 111.
REQ-035 Deassert enable during SHIFT of row 5 -> row 5 completes through ON, the FSM enters IDLE with OEB=1, and re-enable restarts at row_addr=0 with a frame_start pulse.
REQ-036 Assert reset during ON of row 3 -> next cycle OEB=1, all clocks 0 and row_addr=0; nothing is emitted while reset is held.
REQ-037 Bench monitor -> CSDI never changes while CCLK=1; LE=1 only while OEB=1; OEB=0 only in ON.
